// File: rtl/hazard_pkg.sv
// Shared constants for the hazard scoreboard slice.
//   fwd_sel_e        : forwarding mux select encodings.
//   REGADDR_W_DEF    : default register address width.
//   LAT_W_DEF        : default latency countdown width.
// Optional feature macro used by hazard_scoreboard: HAZ_PERF_CNT_EN.
package hazard_pkg;

  localparam int unsigned REGADDR_W_DEF = 4;
  localparam int unsigned LAT_W_DEF     = 3;
  localparam int unsigned PERF_W        = 32;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_WB    = 2'b01,
    FWD_EXMEM = 2'b10,
    FWD_LU    = 2'b11
  } fwd_sel_e;

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: a countdown of cycles until the register's result is forwardable.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (takes priority over the decrement)
//   load_val   : issue latency to load
//   cnt        : current countdown value
//   busy       : cnt is nonzero
module hazard_sb_entry
  import hazard_pkg::*;
#(
  parameter int unsigned LAT_WIDTH = LAT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [LAT_WIDTH-1:0] load_val,
  output logic [LAT_WIDTH-1:0] cnt,
  output logic                 busy
);

  // Load wins over decrement; an idle entry sits at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - LAT_WIDTH'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// EX-stage operand forwarding plus per-register latency scoreboard, between ID and EX.
//   issue_*            : instruction presented in ID (dest, latency, sources)
//   flush              : squash the ID instruction this cycle
//   ex_mem_*, lu_*, wb_*: result producers visible for forwarding
//   id_ex_rs/rt        : EX-stage source registers
//   stall              : hold PC and IF/ID, bubble ID/EX (combinational)
//   forwardA/forwardB  : operand source selects (combinational, fwd_sel_e)
//   stall_cnt          : stall-cycle counter when HAZ_PERF_CNT_EN is defined, else 0
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REGADDR_WIDTH = REGADDR_W_DEF,
  parameter int unsigned NUM_REGS      = 2 ** REGADDR_WIDTH,
  parameter int unsigned LAT_WIDTH     = LAT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  input  logic                     issue_reg_write,
  input  logic [REGADDR_WIDTH-1:0] issue_rd,
  input  logic [LAT_WIDTH-1:0]     issue_lat,
  input  logic                     issue_rs_used,
  input  logic                     issue_rt_used,
  input  logic [REGADDR_WIDTH-1:0] issue_rs,
  input  logic [REGADDR_WIDTH-1:0] issue_rt,
  input  logic                     flush,
  input  logic                     ex_mem_reg_write,
  input  logic [REGADDR_WIDTH-1:0] ex_mem_rd,
  input  logic                     lu_valid,
  input  logic [REGADDR_WIDTH-1:0] lu_rd,
  input  logic                     wb_reg_write,
  input  logic [REGADDR_WIDTH-1:0] wb_rd,
  input  logic [REGADDR_WIDTH-1:0] id_ex_rs,
  input  logic [REGADDR_WIDTH-1:0] id_ex_rt,
  output logic                     stall,
  output logic [1:0]               forwardA,
  output logic [1:0]               forwardB,
  output logic [PERF_W-1:0]        stall_cnt
);

  logic [NUM_REGS-1:0][LAT_WIDTH-1:0] pend;
  logic [NUM_REGS-1:0]                busy;
  logic                               load_en;
  logic                               raw_hit;
  logic                               waw_hit;

  // r0 is hardwired: never pending, never stalls.
  assign pend[0] = '0;
  assign busy[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    hazard_sb_entry #(
      .LAT_WIDTH (LAT_WIDTH)
    ) u_entry (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load_en && (issue_rd == REGADDR_WIDTH'(r))),
      .load_val (issue_lat),
      .cnt      (pend[r]),
      .busy     (busy[r])
    );
  end

  // Hazard detection from registered pend and current ID inputs.
  always_comb begin
    raw_hit = (issue_rs_used && busy[issue_rs]) || (issue_rt_used && busy[issue_rt]);
    waw_hit = issue_reg_write && (issue_rd != '0) && (pend[issue_rd] > issue_lat);
    stall   = issue_valid && !flush && (raw_hit || waw_hit);
    // Zero-latency results need no tracking; forwarding covers them.
    load_en = issue_valid && !stall && !flush && issue_reg_write &&
              (issue_rd != '0) && (issue_lat != '0);
  end

  // Forwarding priority: EX/MEM, then LU, then WB.
  function automatic logic [1:0] fwd_sel(input logic [REGADDR_WIDTH-1:0] src);
    logic [1:0] sel;
    sel = FWD_NONE;
    if (ex_mem_reg_write && (ex_mem_rd != '0) && (ex_mem_rd == src)) begin
      sel = FWD_EXMEM;
    end else if (lu_valid && (lu_rd != '0) && (lu_rd == src)) begin
      sel = FWD_LU;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  always_comb begin
    forwardA = fwd_sel(id_ex_rs);
    forwardB = fwd_sel(id_ex_rt);
  end

`ifdef HAZ_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + PERF_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: behavioural scoreboard model plus directed literal checks.
module tb_hazard_scoreboard;

  localparam int unsigned RW = 4;
  localparam int unsigned LW = 3;
`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          issue_valid, issue_reg_write, issue_rs_used, issue_rt_used, flush;
  logic [RW-1:0] issue_rd, issue_rs, issue_rt;
  logic [LW-1:0] issue_lat;
  logic          ex_mem_reg_write, lu_valid, wb_reg_write;
  logic [RW-1:0] ex_mem_rd, lu_rd, wb_rd, id_ex_rs, id_ex_rt;
  logic          stall;
  logic [1:0]    forwardA, forwardB;
  logic [31:0]   stall_cnt;

  hazard_scoreboard dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .issue_valid      (issue_valid),
    .issue_reg_write  (issue_reg_write),
    .issue_rd         (issue_rd),
    .issue_lat        (issue_lat),
    .issue_rs_used    (issue_rs_used),
    .issue_rt_used    (issue_rt_used),
    .issue_rs         (issue_rs),
    .issue_rt         (issue_rt),
    .flush            (flush),
    .ex_mem_reg_write (ex_mem_reg_write),
    .ex_mem_rd        (ex_mem_rd),
    .lu_valid         (lu_valid),
    .lu_rd            (lu_rd),
    .wb_reg_write     (wb_reg_write),
    .wb_rd            (wb_rd),
    .id_ex_rs         (id_ex_rs),
    .id_ex_rt         (id_ex_rt),
    .stall            (stall),
    .forwardA         (forwardA),
    .forwardB         (forwardB),
    .stall_cnt        (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int unsigned m_pend [16];
  longint      m_cnt;
  bit          m_s;
  bit          m_ld;

  function automatic bit exp_stall();
    if (!issue_valid || flush) return 1'b0;
    if (issue_rs_used && m_pend[issue_rs] != 0) return 1'b1;
    if (issue_rt_used && m_pend[issue_rt] != 0) return 1'b1;
    if (issue_reg_write && issue_rd != 0 && m_pend[issue_rd] > int'(issue_lat)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [RW-1:0] src);
    if (ex_mem_reg_write && ex_mem_rd != 0 && ex_mem_rd == src) return 2'b10;
    if (lu_valid && lu_rd != 0 && lu_rd == src) return 2'b11;
    if (wb_reg_write && wb_rd != 0 && wb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  always @(negedge rst_n) begin
    for (int r = 0; r < 16; r++) m_pend[r] = 0;
    m_cnt = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      m_s  = exp_stall();
      m_ld = issue_valid && !m_s && !flush && issue_reg_write && issue_rd != 0 && issue_lat != 0;
      for (int r = 0; r < 16; r++) if (m_pend[r] != 0) m_pend[r] = m_pend[r] - 1;
      if (m_ld) m_pend[issue_rd] = int'(issue_lat);
      if (m_s && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
  end

  // Per-cycle comparison on the inactive clock edge.
  always @(negedge clk) begin
    check("stall", 32'(stall), 32'(exp_stall()));
    check("forwardA", 32'(forwardA), 32'(exp_fwd(id_ex_rs)));
    check("forwardB", 32'(forwardB), 32'(exp_fwd(id_ex_rt)));
    check("stall_cnt", stall_cnt, PERF_EN ? 32'(m_cnt) : 32'd0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    issue_valid = 0; issue_reg_write = 0; issue_rd = 0; issue_lat = 0;
    issue_rs_used = 0; issue_rt_used = 0; issue_rs = 0; issue_rt = 0; flush = 0;
    ex_mem_reg_write = 0; ex_mem_rd = 0; lu_valid = 0; lu_rd = 0;
    wb_reg_write = 0; wb_rd = 0; id_ex_rs = 0; id_ex_rt = 0;
  endtask

  task automatic issue(input bit we, input int rd, input int lat,
                       input bit rsu, input int rs, input bit rtu, input int rt);
    issue_valid = 1; flush = 0;
    issue_reg_write = we; issue_rd = RW'(rd); issue_lat = LW'(lat);
    issue_rs_used = rsu; issue_rs = RW'(rs);
    issue_rt_used = rtu; issue_rt = RW'(rt);
  endtask

  task automatic rand_inputs();
    issue_valid      = 1'($urandom_range(0, 3) != 0);
    issue_reg_write  = 1'($urandom_range(0, 1));
    issue_rd         = RW'($urandom_range(0, 7));
    issue_lat        = ($urandom_range(0, 2) == 0) ? LW'(0) : LW'($urandom_range(1, 7));
    issue_rs_used    = 1'($urandom_range(0, 1));
    issue_rt_used    = 1'($urandom_range(0, 1));
    issue_rs         = RW'($urandom_range(0, 7));
    issue_rt         = RW'($urandom_range(0, 7));
    flush            = 1'($urandom_range(0, 9) == 0);
    ex_mem_reg_write = 1'($urandom_range(0, 1));
    ex_mem_rd        = RW'($urandom_range(0, 7));
    lu_valid         = 1'($urandom_range(0, 1));
    lu_rd            = RW'($urandom_range(0, 7));
    wb_reg_write     = 1'($urandom_range(0, 1));
    wb_rd            = RW'($urandom_range(0, 7));
    id_ex_rs         = RW'($urandom_range(0, 7));
    id_ex_rt         = RW'($urandom_range(0, 7));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    clr();
    rst_n = 1'b0;

    // Reset held with random inputs.
    repeat (4) begin
      cyc(); rand_inputs();
      #2 check("rst_stall", 32'(stall), 32'd0);
      check("rst_cnt", stall_cnt, 32'd0);
    end
    cyc(); clr(); rst_n = 1'b1;

    // Load-use: lat=1 load then dependent op -> exactly one stall cycle.
    cyc(); issue(1, 5, 1, 0, 0, 0, 0);
    #2 check("lu_issue_stall", 32'(stall), 32'd0);
    cyc(); issue(1, 6, 0, 1, 5, 0, 0);
    #2 check("lu_dep_stall", 32'(stall), 32'd1);
    cyc(); wb_reg_write = 1; wb_rd = 5; id_ex_rs = 5;
    #2 check("lu_dep_release", 32'(stall), 32'd0);
    check("lu_fwd_wb", 32'(forwardA), 32'd1);

    // Divider: lat=6 then dependent rt -> six stall cycles, then LU forward.
    cyc(); clr(); issue(1, 3, 6, 0, 0, 0, 0);
    cyc(); issue(0, 0, 0, 0, 0, 1, 3);
    for (int i = 0; i < 6; i++) begin
      #2 check("div_stall", 32'(stall), 32'd1);
      cyc();
    end
    #2 check("div_release", 32'(stall), 32'd0);
    lu_valid = 1; lu_rd = 3; id_ex_rt = 3;
    #1 check("div_fwd_lu", 32'(forwardB), 32'd3);

    // Forward priority.
    cyc(); clr();
    ex_mem_reg_write = 1; ex_mem_rd = 7; lu_valid = 1; lu_rd = 7;
    wb_reg_write = 1; wb_rd = 7; id_ex_rs = 7;
    #2 check("prio_exmem", 32'(forwardA), 32'd2);
    cyc(); ex_mem_reg_write = 0;
    #2 check("prio_lu", 32'(forwardA), 32'd3);
    cyc(); lu_valid = 0;
    #2 check("prio_wb", 32'(forwardA), 32'd1);

    // WAW, flush, and register 0.
    cyc(); clr(); issue(1, 4, 5, 0, 0, 0, 0);
    cyc(); issue(1, 4, 1, 0, 0, 0, 0);
    #2 check("waw_stall", 32'(stall), 32'd1);
    flush = 1;
    #1 check("flush_stall", 32'(stall), 32'd0);
    cyc(); issue(1, 4, 3, 0, 0, 0, 0);
    #2 check("flush_no_reload", 32'(stall), 32'd1);
    cyc(); clr(); issue(1, 0, 0, 1, 0, 1, 0);
    ex_mem_reg_write = 1; lu_valid = 1; wb_reg_write = 1;
    #2 check("r0_stall", 32'(stall), 32'd0);
    check("r0_fwdA", 32'(forwardA), 32'd0);
    check("r0_fwdB", 32'(forwardB), 32'd0);

    // Randomized traffic checked by the model.
    repeat (3000) begin
      cyc(); rand_inputs();
    end

    // Perf counter over a clean six-cycle stall, then reset mid-stall.
    cyc(); clr(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
    cyc(); issue(1, 2, 6, 0, 0, 0, 0);
    cyc(); issue(0, 0, 0, 1, 2, 0, 0);
    repeat (6) cyc();
    #2 check("perf_release", 32'(stall), 32'd0);
    check("perf_cnt6", stall_cnt, PERF_EN ? 32'd6 : 32'd0);
    cyc(); clr(); issue(1, 2, 6, 0, 0, 0, 0);
    cyc(); issue(0, 0, 0, 1, 2, 0, 0);
    cyc(); cyc();
    #2 check("mid_stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1 check("rst_mid_stall", 32'(stall), 32'd0);
    check("rst_mid_cnt", stall_cnt, 32'd0);
    cyc(); rst_n = 1'b1; clr();
    repeat (3) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
